// File: rtl/gc_poll_scheduler.sv
// gc_poll_scheduler: frames GameCube polls over NPORTS ports sharing one transceiver,
// triggered by USB in_ready or a free-running period timer, with per-port miss tracking.
module gc_poll_scheduler #(
    parameter int NPORTS = 2,
    parameter int PERIOD_CYC = 60000,
    parameter int TIMEOUT_CYC = 30000,
    parameter int GAP_CYC = 600,
    parameter int MISS_LIMIT = 3,
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_ready_i,
    input  logic [NPORTS-1:0]    port_en_i,
    input  logic [NPORTS-1:0]    rumble_i,
    output logic                 txn_start_o,
    output logic [PW-1:0]        txn_port_o,
    output logic                 txn_rumble_o,
    input  logic                 txn_done_i,
    input  logic                 txn_err_i,
    input  logic [63:0]          txn_data_i,
    output logic [NPORTS*64-1:0] report_o,
    output logic [NPORTS-1:0]    report_valid_o,
    output logic                 frame_busy_o,
    output logic                 frame_done_o
);
    localparam int MAXC = (PERIOD_CYC > TIMEOUT_CYC)
        ? ((PERIOD_CYC > GAP_CYC) ? PERIOD_CYC : GAP_CYC)
        : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam int IW = $clog2(NPORTS + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, SCAN, START, WAIT, GAP, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        tmr_q, cnt_q;
    logic [IW-1:0]        idx_q, base;
    logic [PW-1:0]        nxt, port_q;
    logic                 rumble_q, pending_q, tick, trig, found, tmo, ends;
    logic [NPORTS*64-1:0] report_q;
    logic [NPORTS-1:0]    valid_q;
    logic [MW-1:0]        miss_q [NPORTS];
    logic [MW-1:0]        miss_sat;

    assign tick = tmr_q == CW'(PERIOD_CYC - 1);
    assign trig = in_ready_i | tick;
    assign tmo = cnt_q == CW'(TIMEOUT_CYC - 1);
    assign ends = txn_done_i | tmo;
    assign miss_sat = (miss_q[port_q] == MW'(MISS_LIMIT)) ? miss_q[port_q] : miss_q[port_q] + 1'b1;

    // In WAIT the search looks past the current port to decide between GAP and DONE.
    always_comb begin
        base = (state_q == WAIT) ? idx_q + 1'b1 : idx_q;
        found = 1'b0;
        nxt = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (port_en_i[i] && i >= int'(base)) begin
                found = 1'b1;
                nxt = PW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = trig ? SCAN : IDLE;
            SCAN:    state_d = found ? START : DONE;
            START:   state_d = WAIT;
            WAIT:    state_d = ends ? (found ? GAP : DONE) : WAIT;
            GAP:     state_d = (cnt_q == CW'(GAP_CYC - 1)) ? SCAN : GAP;
            DONE:    state_d = (pending_q || trig) ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            port_q <= '0;
            rumble_q <= 1'b0;
            pending_q <= 1'b0;
            report_q <= '0;
            valid_q <= '0;
            for (int p = 0; p < NPORTS; p++) miss_q[p] <= '0;
        end else begin
            state_q <= state_d;
            tmr_q <= tick ? '0 : tmr_q + 1'b1;
            cnt_q <= (state_d == state_q && (state_q == WAIT || state_q == GAP)) ? cnt_q + 1'b1 : '0;
            pending_q <= (state_q == DONE) ? 1'b0 : pending_q | (trig & frame_busy_o);
            if (state_q == SCAN && found) begin
                idx_q <= IW'(nxt);
                port_q <= nxt;
                rumble_q <= rumble_i[nxt];
            end
            if (state_q == WAIT && ends) begin
                idx_q <= idx_q + 1'b1;
                if (txn_done_i && !txn_err_i) begin
                    report_q[int'(port_q)*64 +: 64] <= txn_data_i;
                    valid_q[port_q] <= 1'b1;
                    miss_q[port_q] <= '0;
                end else begin
                    miss_q[port_q] <= miss_sat;
                    if (miss_sat == MW'(MISS_LIMIT)) valid_q[port_q] <= 1'b0;
                end
            end
            if (state_q == DONE) idx_q <= '0;
        end
    end

    assign txn_start_o = state_q == START;
    assign txn_port_o = port_q;
    assign txn_rumble_o = rumble_q;
    assign report_o = report_q;
    assign report_valid_o = valid_q;
    assign frame_busy_o = state_q != IDLE && state_q != DONE;
    assign frame_done_o = state_q == DONE;
endmodule

// File: tb/tb_gc_poll_scheduler.sv
// tb_gc_poll_scheduler: randomized frames against a cycle-timed reference of frame/port sequencing,
// trigger pending and per-port report/miss bookkeeping.
module tb_gc_poll_scheduler;
    localparam int N = 2, P = 1000, T = 150, G = 16, L = 3;

    logic           clk = 1'b0, rst = 1'b1, in_ready_i = 1'b0, txn_done_i = 1'b0, txn_err_i = 1'b0;
    logic [N-1:0]   port_en_i = '0, rumble_i = '0;
    logic [63:0]    txn_data_i = '0;
    logic           txn_start_o, txn_rumble_o, frame_busy_o, frame_done_o;
    logic [0:0]     txn_port_o;
    logic [N*64-1:0] report_o;
    logic [N-1:0]   report_valid_o;

    int n_chk = 0, n_fail = 0, cyc = 0, r0 = 0, iter = 0;
    bit m_busy = 0, m_pend = 0, gen_ir = 0;
    logic [63:0] rep [N];
    bit val [N];
    int miss [N];

    gc_poll_scheduler #(.NPORTS(N), .PERIOD_CYC(P), .TIMEOUT_CYC(T), .GAP_CYC(G), .MISS_LIMIT(L)) dut (
        .clk(clk), .rst(rst), .in_ready_i(in_ready_i), .port_en_i(port_en_i), .rumble_i(rumble_i),
        .txn_start_o(txn_start_o), .txn_port_o(txn_port_o), .txn_rumble_o(txn_rumble_o),
        .txn_done_i(txn_done_i), .txn_err_i(txn_err_i), .txn_data_i(txn_data_i),
        .report_o(report_o), .report_valid_o(report_valid_o),
        .frame_busy_o(frame_busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [N*64-1:0] got, input logic [N*64-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_tick(input int c);
        return (c - r0) % P == P - 1;
    endfunction

    function automatic logic [N*64-1:0] exp_rep();
        logic [N*64-1:0] r;
        for (int i = 0; i < N; i++) r[i*64 +: 64] = rep[i];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_val();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = val[i];
        return v;
    endfunction

    // 0 good, 1 error, 2 no answer, 3 good on the very cycle the timeout expires
    function automatic int pick_mode(input int p);
        int r;
        if (iter == 0 || (iter == 5 && p == 0)) return 0;
        if (iter >= 1 && iter <= 4 && p == 0) return 2;
        r = $urandom_range(0, 9);
        return (r < 4) ? 0 : (r == 4) ? 3 : (r < 7) ? 1 : 2;
    endfunction

    task automatic step();
        if ((in_ready_i || is_tick(cyc)) && m_busy) m_pend = 1;
        @(posedge clk);
        #1;
        cyc++;
        txn_done_i = 1'b0;
        in_ready_i = gen_ir && m_busy && ($urandom_range(0, 149) == 0);
    endtask

    task automatic go_to(input int target, input int stray, input string tag);
        bit spur = 0;
        while (cyc < target) begin
            if (cyc == stray) begin
                txn_done_i = 1'b1;
                txn_err_i = 1'($urandom_range(0, 1));
                txn_data_i = {$urandom, $urandom};
            end
            step();
            if (cyc < target && (txn_start_o || frame_done_o)) spur = 1;
        end
        chk({tag, "_quiet"}, spur, 0);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_start"}, txn_start_o, 0);
        chk({tag, "_port"}, txn_port_o, 0);
        chk({tag, "_rumble"}, txn_rumble_o, 0);
        chk({tag, "_report"}, report_o, 0);
        chk({tag, "_valid"}, report_valid_o, 0);
        chk({tag, "_busy"}, frame_busy_o, 0);
        chk({tag, "_done"}, frame_done_o, 0);
    endtask

    task automatic frame(input int t, output int f);
        int p, np, s, e, k, mode;
        bit first, fin;
        logic [63:0] d;
        step();
        m_busy = 1;
        chk("busy_on", frame_busy_o, 1);
        p = -1;
        first = 1;
        fin = 0;
        e = t;
        f = t;
        while (!fin) begin
            np = -1;
            for (int i = N - 1; i > p; i--) if (port_en_i[i]) np = i;
            if (np < 0) begin
                go_to(first ? t + 2 : e + 1, -1, "to_done");
                chk("frame_done", frame_done_o, 1);
                chk("busy_off", frame_busy_o, 0);
                chk("report", report_o, exp_rep());
                chk("valid", report_valid_o, exp_val());
                m_busy = 0;
                f = cyc;
                fin = 1;
            end else begin
                go_to(first ? t + 2 : e + G + 2, first ? -1 : e + 2, "to_start");
                chk("txn_start", txn_start_o, 1);
                chk("txn_port", txn_port_o, np);
                chk("txn_rumble", txn_rumble_o, rumble_i[np]);
                s = cyc;
                mode = pick_mode(np);
                k = (mode >= 2) ? T : $urandom_range(1, 40);
                e = s + k;
                go_to(e, -1, "to_resp");
                chk("port_stable", txn_port_o, np);
                d = {$urandom, $urandom};
                if (mode != 2) begin
                    txn_done_i = 1'b1;
                    txn_err_i = mode == 1;
                    txn_data_i = d;
                end
                if (mode == 0 || mode == 3) begin
                    rep[np] = d;
                    val[np] = 1;
                    miss[np] = 0;
                end else begin
                    if (miss[np] < L) miss[np]++;
                    if (miss[np] == L) val[np] = 0;
                end
                p = np;
                first = 0;
            end
        end
    endtask

    task automatic run_chain(input int t0);
        int t, f;
        bit cont;
        t = t0;
        do begin
            frame(t, f);
            cont = m_pend || in_ready_i || is_tick(f);
            m_pend = 0;
            t = f;
        end while (cont);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rep[i] = '0;
            val[i] = 0;
            miss[i] = 0;
        end
        repeat (3) step();
        rst_chk("reset");
        rst = 1'b0;
        r0 = cyc;
        port_en_i = 2'b11;
        rumble_i = 2'b01;
        in_ready_i = 1'b1;
        step();
        step();
        chk("pre_rst_start", txn_start_o, 1);
        chk("pre_rst_port", txn_port_o, 0);
        chk("pre_rst_rumble", txn_rumble_o, 1);
        repeat (5) step();
        chk("pre_rst_busy", frame_busy_o, 1);
        rst = 1'b1;
        step();
        rst_chk("mid_rst");
        rst = 1'b0;
        r0 = cyc;
        gen_ir = 1;
        for (iter = 0; iter < 30; iter++) begin
            if (iter >= 6) port_en_i = N'($urandom_range(0, 3));
            rumble_i = N'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) while (!is_tick(cyc)) step();
            else in_ready_i = 1'b1;
            run_chain(cyc);
            step();
            chk("idle", frame_busy_o, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
